// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-unit state encoding.
// The ALU decoder imports this package, so the execute unit and the decoder always agree on codes.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative one-bit-per-cycle shifter: holds the working value and a down-counter.
// done marks the cycle whose closing edge performs the last shift.
module seq_alu_shifter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_value,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic             dir_q;

  // dir: 0 shifts left, 1 shifts right; both fill with zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work  <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else if (start) begin
      work  <= load_value;
      count <= amount;
      dir_q <= dir;
    end else if (count != '0) begin
      work  <= dir_q ? (work >> 1) : (work << 1);
      count <= count - SHW'(1);
    end
  end

  assign busy  = (count != '0);
  assign done  = (count == SHW'(1));
  assign value = work;

endmodule

// File: rtl/seq_alu_exec.sv
// Sequential ALU execute unit with valid/ready handshake, registered result and branch flags.
// Define SEQ_ALU_FAST_SHIFT_EN for single-cycle barrel shifts; otherwise shifts run one bit per cycle.
module seq_alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             illegal
);

  state_t           state, state_next;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] diff;
  logic             sub_lt;
  logic [WIDTH-1:0] alu_value;
  logic             alu_lt;
  logic             alu_illegal;
  logic [WIDTH-1:0] result_q;
  logic             lt_q;
  logic             illegal_q;
  logic [WIDTH-1:0] final_value;

  assign in_ready = reset_n && (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHW-1:0];
  assign diff     = src_a - src_b;
  // Signed compare from the subtractor: sign of the difference corrected by overflow
  assign sub_lt   = diff[WIDTH-1] ^ ((src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                                     (diff[WIDTH-1] != src_a[WIDTH-1]));

`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic             shift_op;
  logic             start_shift;
  logic             shift_busy;
  logic             shift_done;
  logic             use_shifter_q;
  logic [WIDTH-1:0] shift_value;

  assign shift_op    = (alu_control == ALU_SHL) || (alu_control == ALU_SHR);
  assign start_shift = accept && shift_op && (shamt != '0);

  seq_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_shift),
    .dir        (alu_control[2]),
    .load_value (src_a),
    .amount     (shamt),
    .busy       (shift_busy),
    .done       (shift_done),
    .value      (shift_value)
  );
`endif

  always_comb begin
    alu_value   = '0;
    alu_lt      = 1'b0;
    alu_illegal = 1'b0;
    case (alu_control)
      ALU_ADD: alu_value = src_a + src_b;
      ALU_SUB: begin
        alu_value = diff;
        alu_lt    = sub_lt;
      end
      ALU_XOR: alu_value = src_a ^ src_b;
      ALU_OR:  alu_value = src_a | src_b;
      ALU_AND: alu_value = src_a & src_b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      ALU_SHL: alu_value = src_a << shamt;
      ALU_SHR: alu_value = src_a >> shamt;
`else
      // Zero-amount shifts complete here; non-zero amounts take their value from the shifter
      ALU_SHL: alu_value = src_a;
      ALU_SHR: alu_value = src_a;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
          state_next = ST_DONE;
`else
          state_next = start_shift ? ST_SHIFT : ST_DONE;
`endif
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      ST_SHIFT: begin
        if (shift_done || !shift_busy) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q      <= '0;
      lt_q          <= 1'b0;
      illegal_q     <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      use_shifter_q <= 1'b0;
`endif
    end else if (accept) begin
      result_q      <= alu_value;
      lt_q          <= alu_lt;
      illegal_q     <= alu_illegal;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      use_shifter_q <= start_shift;
`endif
    end
  end

`ifdef SEQ_ALU_FAST_SHIFT_EN
  assign final_value = result_q;
`else
  assign final_value = use_shifter_q ? shift_value : result_q;
`endif

  // All outputs read as zero unless a result is being presented
  assign out_valid = (state == ST_DONE);
  assign result    = out_valid ? final_value : '0;
  assign zero      = out_valid && (final_value == '0);
  assign lt        = out_valid && lt_q;
  assign illegal   = out_valid && illegal_q;

endmodule
